// File: rtl/rx_frame_module.sv
// rtl/rx_frame_module.sv - UART byte stream to checked command frame parser
module rx_frame_module #(
  parameter logic [7:0]  HEADER      = 8'h55,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        Rx_Done_Sig,
  input  logic [7:0]  Rx_Data,
  input  logic        Frame_Ack,
  output logic        Rx_En_Sig,
  output logic        Frame_Valid,
  output logic [7:0]  Frame_Cmd,
  output logic [3:0]  Frame_Len,
  output logic [63:0] Frame_Data,
  output logic        Err_Sig,
  output logic [1:0]  Err_Code
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_DATA, S_SUM, S_HOLD} state_t;

  // Last count value before an inter-byte gap is declared a timeout.
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [3:0]  len_q, len_d;
  logic [63:0] shadow_q, shadow_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  xor_q, xor_d;
  logic [19:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [7:0]  fcmd_q, fcmd_d;
  logic [3:0]  flen_q, flen_d;
  logic [63:0] fdata_q, fdata_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        rx_en_q, rx_en_d;

  // State and datapath registers; everything clears asynchronously.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      len_q    <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      xor_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      fcmd_q   <= '0;
      flen_q   <= '0;
      fdata_q  <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
      rx_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      xor_q    <= xor_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      fcmd_q   <= fcmd_d;
      flen_q   <= flen_d;
      fdata_q  <= fdata_d;
      err_q    <= err_d;
      code_q   <= code_d;
      rx_en_q  <= rx_en_d;
    end
  end

  // Frame parsing, inter-byte timeout and output staging.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    fcmd_d   = fcmd_q;
    flen_d   = flen_q;
    fdata_d  = fdata_q;
    err_d    = 1'b0;
    code_d   = code_q;
    rx_en_d  = rx_en_q;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        rx_en_d = 1'b1;
        if (Rx_Done_Sig && (Rx_Data == HEADER)) begin
          shadow_d = '0;
          state_d  = S_CMD;
        end
      end
      S_CMD, S_LEN, S_DATA, S_SUM: begin
        rx_en_d = 1'b1;
        if (Rx_Done_Sig) begin
          // A byte in the final count cycle still counts as on time.
          cnt_d = '0;
          case (state_q)
            S_CMD: begin
              cmd_d   = Rx_Data;
              xor_d   = Rx_Data;
              state_d = S_LEN;
            end
            S_LEN: begin
              if (Rx_Data > 8'd8) begin
                err_d   = 1'b1;
                code_d  = 2'd2;
                state_d = S_IDLE;
              end else begin
                len_d   = Rx_Data[3:0];
                xor_d   = xor_q ^ Rx_Data;
                idx_d   = '0;
                state_d = (Rx_Data == 8'd0) ? S_SUM : S_DATA;
              end
            end
            S_DATA: begin
              shadow_d[{idx_q[2:0], 3'b000} +: 8] = Rx_Data;
              xor_d = xor_q ^ Rx_Data;
              idx_d = idx_q + 4'd1;
              if ((idx_q + 4'd1) == len_q) state_d = S_SUM;
            end
            default: begin
              if (Rx_Data == xor_q) begin
                fcmd_d  = cmd_q;
                flen_d  = len_q;
                fdata_d = shadow_q;
                valid_d = 1'b1;
                rx_en_d = 1'b0;
                state_d = S_HOLD;
              end else begin
                err_d   = 1'b1;
                code_d  = 2'd1;
                state_d = S_IDLE;
              end
            end
          endcase
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        if (Frame_Ack) begin
          valid_d = 1'b0;
          rx_en_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Rx_En_Sig   = rx_en_q;
  assign Frame_Valid = valid_q;
  assign Frame_Cmd   = fcmd_q;
  assign Frame_Len   = flen_q;
  assign Frame_Data  = fdata_q;
  assign Err_Sig     = err_q;
  assign Err_Code    = code_q;

endmodule

// File: tb/tb_rx_frame_module.sv
// tb/tb_rx_frame_module.sv - directed self-checking bench for rx_frame_module
module tb_rx_frame_module;

  logic        CLK;
  logic        RST_n;
  logic        Rx_Done_Sig;
  logic [7:0]  Rx_Data;
  logic        Frame_Ack;
  logic        Rx_En_Sig;
  logic        Frame_Valid;
  logic [7:0]  Frame_Cmd;
  logic [3:0]  Frame_Len;
  logic [63:0] Frame_Data;
  logic        Err_Sig;
  logic [1:0]  Err_Code;

  int passed = 0;
  int total  = 0;

  rx_frame_module #(.HEADER(8'h55), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RST_n(RST_n), .Rx_Done_Sig(Rx_Done_Sig), .Rx_Data(Rx_Data),
    .Frame_Ack(Frame_Ack), .Rx_En_Sig(Rx_En_Sig), .Frame_Valid(Frame_Valid),
    .Frame_Cmd(Frame_Cmd), .Frame_Len(Frame_Len), .Frame_Data(Frame_Data),
    .Err_Sig(Err_Sig), .Err_Code(Err_Code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    Rx_Done_Sig = 1'b1;
    Rx_Data     = b;
    @(negedge CLK);
    Rx_Done_Sig = 1'b0;
    Rx_Data     = 8'h00;
  endtask

  task automatic ack();
    @(negedge CLK);
    Frame_Ack = 1'b1;
    @(negedge CLK);
    Frame_Ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_en"}, 64'(Rx_En_Sig), 64'd0);
    check({tag, "_valid"}, 64'(Frame_Valid), 64'd0);
    check({tag, "_cmd"}, 64'(Frame_Cmd), 64'd0);
    check({tag, "_len"}, 64'(Frame_Len), 64'd0);
    check({tag, "_data"}, Frame_Data, 64'd0);
    check({tag, "_err"}, 64'(Err_Sig), 64'd0);
    check({tag, "_code"}, 64'(Err_Code), 64'd0);
  endtask

  initial begin
    RST_n = 1'b0; Rx_Done_Sig = 1'b0; Rx_Data = 8'h00; Frame_Ack = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("por");
    RST_n = 1'b1;
    @(negedge CLK);
    check("por_rx_en_rise", 64'(Rx_En_Sig), 64'd1);

    // Good two-byte frame, then bytes ignored in HOLD, then ack.
    send_byte(8'h55); send_byte(8'hA1); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20);
    check("pre_sum_valid", 64'(Frame_Valid), 64'd0);
    send_byte(8'h93);
    check("f1_valid", 64'(Frame_Valid), 64'd1);
    check("f1_cmd", 64'(Frame_Cmd), 64'hA1);
    check("f1_len", 64'(Frame_Len), 64'd2);
    check("f1_data", Frame_Data, 64'h2010);
    check("f1_rx_en", 64'(Rx_En_Sig), 64'd0);
    send_byte(8'h55);
    repeat (3) @(negedge CLK);
    check("hold_valid", 64'(Frame_Valid), 64'd1);
    check("hold_rx_en", 64'(Rx_En_Sig), 64'd0);
    ack();
    check("ack_valid", 64'(Frame_Valid), 64'd0);
    check("ack_rx_en", 64'(Rx_En_Sig), 64'd1);
    check("ack_cmd_kept", 64'(Frame_Cmd), 64'hA1);
    check("ack_data_kept", Frame_Data, 64'h2010);

    // Zero-length frame, then stray bytes without a header.
    send_byte(8'h55); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    check("f0_valid", 64'(Frame_Valid), 64'd1);
    check("f0_cmd", 64'(Frame_Cmd), 64'h07);
    check("f0_len", 64'(Frame_Len), 64'd0);
    check("f0_data", Frame_Data, 64'd0);
    ack();
    send_byte(8'h12); send_byte(8'h34);
    check("stray_valid", 64'(Frame_Valid), 64'd0);
    check("stray_cmd", 64'(Frame_Cmd), 64'h07);
    check("stray_err", 64'(Err_Sig), 64'd0);

    // Bad checksum, then a good one-byte frame.
    send_byte(8'h55); send_byte(8'hA1); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h94);
    check("csum_err", 64'(Err_Sig), 64'd1);
    check("csum_code", 64'(Err_Code), 64'd1);
    check("csum_valid", 64'(Frame_Valid), 64'd0);
    check("csum_cmd_kept", 64'(Frame_Cmd), 64'h07);
    @(negedge CLK);
    check("csum_err_pulse", 64'(Err_Sig), 64'd0);
    send_byte(8'h55); send_byte(8'h3C); send_byte(8'h01); send_byte(8'hAA);
    send_byte(8'h97);
    check("f2_valid", 64'(Frame_Valid), 64'd1);
    check("f2_cmd", 64'(Frame_Cmd), 64'h3C);
    check("f2_len", 64'(Frame_Len), 64'd1);
    check("f2_data", Frame_Data, 64'hAA);
    ack();

    // LEN above 8, then a frame proves the parser went back to IDLE.
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h09);
    check("len_err", 64'(Err_Sig), 64'd1);
    check("len_code", 64'(Err_Code), 64'd2);
    send_byte(8'h55); send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
    check("f3_valid", 64'(Frame_Valid), 64'd1);
    check("f3_cmd", 64'(Frame_Cmd), 64'h05);
    ack();

    // Inter-byte timeout fires on the 16th idle edge.
    send_byte(8'h55); send_byte(8'h01);
    repeat (15) @(negedge CLK);
    check("to_not_yet", 64'(Err_Sig), 64'd0);
    @(negedge CLK);
    check("to_err", 64'(Err_Sig), 64'd1);
    check("to_code", 64'(Err_Code), 64'd3);

    // Byte arriving in the cycle the count reaches 15 wins.
    send_byte(8'h55); send_byte(8'h01);
    repeat (14) @(negedge CLK);
    send_byte(8'h00);
    check("to_edge_no_err", 64'(Err_Sig), 64'd0);
    send_byte(8'h01);
    check("to_edge_valid", 64'(Frame_Valid), 64'd1);
    check("to_edge_cmd", 64'(Frame_Cmd), 64'h01);
    ack();

    // Reset while holding a frame.
    send_byte(8'h55); send_byte(8'hA1); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h93);
    check("pre_rst_valid", 64'(Frame_Valid), 64'd1);
    RST_n = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    check("rst_hold_rx_en", 64'(Rx_En_Sig), 64'd1);

    // Reset in the middle of DATA; the partial frame is dropped.
    send_byte(8'h55); send_byte(8'h11); send_byte(8'h03); send_byte(8'hAA);
    RST_n = 1'b0;
    #1;
    check_reset_outputs("rst_data");
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    check("rst_data_rx_en", 64'(Rx_En_Sig), 64'd1);
    send_byte(8'h33);
    send_byte(8'h55); send_byte(8'h22); send_byte(8'h00); send_byte(8'h22);
    check("post_rst_valid", 64'(Frame_Valid), 64'd1);
    check("post_rst_cmd", 64'(Frame_Cmd), 64'h22);
    check("post_rst_len", 64'(Frame_Len), 64'd0);
    ack();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
